// File: rtl/kernel_3x3_pipe_if.sv
// Window/coefficient/result bus for the 3x3 convolution kernel.
// The master drives windows, coefficient writes and out_ready; the slave drives in_ready and results.
interface kernel_3x3_pipe_if #(
   parameter int unsigned PIX_W  = 13,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned OUT_W  = 13
);
   logic                     coef_we;
   logic [3:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [9*PIX_W-1:0]       win;
   logic                     mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [OUT_W-1:0]         result;
   logic                     sat;

   modport master (
      output coef_we, coef_addr, coef_data, in_valid, win, mode, out_ready,
      input  in_ready, out_valid, result, sat
   );

   modport slave (
      input  coef_we, coef_addr, coef_data, in_valid, win, mode, out_ready,
      output in_ready, out_valid, result, sat
   );
endinterface

// File: rtl/kernel_3x3_pipe.sv
// Three-stage programmable 3x3 convolution: products, row sums, then total/shift/abs/clip.
// Reset coefficients give the legacy sharpen kernel; the whole pipe stalls on a held output.
module kernel_3x3_pipe #(
   parameter int unsigned PIX_W   = 13,
   parameter int unsigned COEF_W  = 8,
   parameter int unsigned OUT_W   = 13,
   parameter int unsigned OUT_MAX = 255,
   parameter int unsigned SHIFT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   kernel_3x3_pipe_if.slave bus
);
   localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
   localparam int unsigned ROW_W  = PROD_W + 2;
   localparam int unsigned SUM_W  = PIX_W + COEF_W + 5;
   localparam logic signed [SUM_W-1:0]  MAX_S  = SUM_W'(OUT_MAX);
   localparam logic signed [COEF_W-1:0] C_ZERO = '0;
   localparam logic signed [COEF_W-1:0] C_NEG1 = '1;
   localparam logic signed [COEF_W-1:0] C_FIVE = COEF_W'(5);

   logic signed [COEF_W-1:0] r_coef [9];
   logic signed [PROD_W-1:0] r_prod [9];
   logic signed [ROW_W-1:0]  r_row  [3];
   logic                     r_v1, r_m1, r_v2, r_m2;
   logic                     r_out_valid, r_sat;
   logic [OUT_W-1:0]         r_result;

   logic                     w_adv;
   logic signed [PROD_W-1:0] w_prod [9];
   logic signed [ROW_W-1:0]  w_row  [3];
   logic signed [SUM_W-1:0]  w_sum, w_shift, w_mag;
   logic [OUT_W-1:0]         w_res;
   logic                     w_sat;

   // Every stage moves together whenever the output register can take a new value.
   assign w_adv         = !r_out_valid || bus.out_ready;
   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.sat       = r_sat;

   // Coefficient bank; a window accepted on the write edge still sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 9; k++)
            r_coef[k] <= (k == 4) ? C_FIVE : ((k % 2) == 1) ? C_NEG1 : C_ZERO;
      end else begin
         for (int k = 0; k < 9; k++)
            if (bus.coef_we && (bus.coef_addr == 4'(k))) r_coef[k] <= bus.coef_data;
      end
   end

   always_comb begin
      for (int k = 0; k < 9; k++)
         w_prod[k] = PROD_W'($signed({1'b0, bus.win[k*PIX_W +: PIX_W]})) * PROD_W'(r_coef[k]);
      for (int r = 0; r < 3; r++)
         w_row[r] = ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_m1 <= 1'b0;
         r_v2 <= 1'b0;
         r_m2 <= 1'b0;
         for (int k = 0; k < 9; k++) r_prod[k] <= '0;
         for (int r = 0; r < 3; r++) r_row[r] <= '0;
      end else if (w_adv) begin
         r_v1 <= bus.in_valid;
         r_v2 <= r_v1;
         if (bus.in_valid) begin
            r_m1 <= bus.mode;
            for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
         end
         if (r_v1) begin
            r_m2 <= r_m1;
            for (int r = 0; r < 3; r++) r_row[r] <= w_row[r];
         end
      end
   end

   // Final sum, floor shift, optional magnitude, then clip into [0, OUT_MAX].
   always_comb begin
      w_sum   = SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]);
      w_shift = w_sum >>> SHIFT;
      w_mag   = (r_m2 && w_shift[SUM_W-1]) ? -w_shift : w_shift;
      w_res   = OUT_W'(w_mag);
      w_sat   = 1'b0;
      if (w_mag[SUM_W-1]) begin
         w_res = '0;
         w_sat = 1'b1;
      end else if (w_mag > MAX_S) begin
         w_res = OUT_W'(OUT_MAX);
         w_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_sat       <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_v2;
         r_result    <= r_v2 ? w_res : '0;
         r_sat       <= r_v2 & w_sat;
      end
   end
endmodule

// File: doc/kernel_3x3_pipe.md
Name: kernel_3x3_pipe

Overview:
- Pipelined, parametrised 3x3 convolution kernel for the image pipeline.
- Successor to the fixed combinational sharpen kernel. Coefficients are run-time programmable, with a right-shift normaliser, a clip or absolute-value output mode, and valid/ready flow control.
- Sits between the 3x3 window generator (upstream) and the output line writer (downstream).
- Reset coefficients reproduce the existing sharpen kernel, so it drops in unchanged.

Parameters:
- PIX_W, 13, unsigned input pixel width.
- COEF_W, 8, signed two's-complement coefficient width.
- OUT_W, 13, output pixel width.
- OUT_MAX, 255, upper clip bound; must be ≤ 2^OUT_W−1.
- SHIFT, 0, arithmetic right shift applied to the sum before clipping (0..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient index 0..8, row-major (0 = top-left, 4 = centre).
- coef_data  in  COEF_W  signed coefficient value.
- in_valid  in  1  window valid.
- in_ready  out  1  kernel accepts a window this cycle.
- win  in  9*PIX_W  pixels p0..p8; p0 in bits [PIX_W-1:0], p8 in the MSBs.
- mode  in  1  sampled with the window: 0 = clip, 1 = absolute value then clip.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  OUT_W  output pixel.
- sat  out  1  result was clipped; qualified by out_valid.

Behaviour:
- Reset (async, rst=1):
  - All stage valid flags clear; out_valid=0, result=0, sat=0.
  - Coefficient bank loads {0,-1,0,-1,5,-1,0,-1,0}.
  - in_ready becomes 1 on the first cycle after rst deasserts.
  - Reset mid-stream discards every in-flight window with no output.
- Coefficient writes:
  - When coef_we=1 and coef_addr≤8, bank[coef_addr] <= coef_data at the clock edge.
  - coef_addr 9..15 is ignored.
  - A write takes effect for windows captured on the next cycle onward. A window accepted in the same cycle as the write uses the old value.
  - In-flight windows are unaffected.
- Pipeline: 3 stages, all advancing together on the enable adv = !out_valid || out_ready.
  - S1, on acceptance (in_valid && in_ready): register the nine products pixel*coef (pixel zero-extended, signed product width PIX_W+COEF_W+1), plus mode and a valid flag.
  - S2: three row sums, width +2 bits, plus mode and valid.
  - S3: total sum, width PIX_W+COEF_W+5 signed. Then:
    - Arithmetic shift right by SHIFT (floor toward −inf).
    - If mode=1, take the absolute value.
    - Clip: v<0 → 0; v>OUT_MAX → OUT_MAX; otherwise v.
    - result and sat are registered together with out_valid.
- Latency: exactly 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 window per cycle.
- Handshake:
  - in_ready = adv, a combinational function of out_valid and out_ready only, with no dependency on in_valid.
  - While out_valid=1 and out_ready=0, the whole pipeline holds; result, sat and out_valid stay stable.
  - Bubbles propagate as invalid stages; out_valid drops when a bubble reaches S3 and is accepted.
- Simultaneous events: out_ready=1 with out_valid=1 and in_valid=1 in the same cycle gives simultaneous accept and deliver, with no bubble inserted.
- sat=1 iff the clip changed the value (negative or >OUT_MAX after shift/abs). It is 0 when out_valid=0.
- No overflow is possible: internal widths cover 9 × max|pixel| × max|coef|.

Test Plan:
- Reset coefficients, mode=0, win all 100 → result 100, sat=0, out_valid exactly 3 cycles after acceptance.
- Reset coefficients, centre 200, neighbours 0 → 1000 → result 255, sat=1. Centre 0, four cross neighbours 50 → −200 → result 0, sat=1.
- Write the Sobel-X set {-1,0,1,-2,0,2,-1,0,1}; left column 200, right column 0; mode=1 → |−800| → 255. With SHIFT=2 build: |−800|>>2 = 200 → 200, sat=0.
- Stream 10 windows with in_valid held high; hold out_ready=0 for 4 cycles mid-stream → in_ready=0 during the stall, result stable, all 10 outputs in order with no loss or duplication.
- Write coef_addr=4 to 9 on the same cycle a window of all 10 is accepted → that window gives 10. The next all-10 window gives 50. A write to coef_addr=12 changes nothing.
- Assert rst for 1 cycle with 2 windows in flight → no out_valid for them, the bank returns to the sharpen kernel, and the next all-100 window gives 100.
